// File: rtl/instr_pkg.sv
// Shared instruction-set definitions: request mnemonics, opcode/funct values
// and word field positions used by the encoder and the matching decoder.
package instr_pkg;

  typedef enum logic [4:0] {
    OP_ADD   = 5'd0,  OP_ADDU  = 5'd1,  OP_SUB   = 5'd2,  OP_SUBU  = 5'd3,
    OP_AND   = 5'd4,  OP_OR    = 5'd5,  OP_SLL   = 5'd6,  OP_SRL   = 5'd7,
    OP_SLT   = 5'd8,  OP_JR    = 5'd9,
    OP_ADDI  = 5'd10, OP_ADDIU = 5'd11, OP_SLTI  = 5'd12, OP_SLTIU = 5'd13,
    OP_ANDI  = 5'd14, OP_ORI   = 5'd15,
    OP_BEQ   = 5'd16, OP_BNE   = 5'd17, OP_BGT   = 5'd18, OP_BGTE  = 5'd19,
    OP_BLE   = 5'd20, OP_BLEQ  = 5'd21,
    OP_J     = 5'd22, OP_JAL   = 5'd23, OP_LW    = 5'd24, OP_SW    = 5'd25
  } op_e;

  typedef enum logic [1:0] {FMT_R, FMT_I, FMT_J} fmt_e;

  localparam logic [5:0] OPC_RTYPE = 6'b000000;
  localparam logic [5:0] OPC_ADDI  = 6'b001000;
  localparam logic [5:0] OPC_ADDIU = 6'b001001;
  localparam logic [5:0] OPC_SLTI  = 6'b001010;
  localparam logic [5:0] OPC_SLTIU = 6'b001011;
  localparam logic [5:0] OPC_ANDI  = 6'b001100;
  localparam logic [5:0] OPC_ORI   = 6'b001101;
  localparam logic [5:0] OPC_BEQ   = 6'b011000;
  localparam logic [5:0] OPC_BNE   = 6'b011001;
  localparam logic [5:0] OPC_BGT   = 6'b011010;
  localparam logic [5:0] OPC_BGTE  = 6'b011011;
  localparam logic [5:0] OPC_BLE   = 6'b011100;
  localparam logic [5:0] OPC_BLEQ  = 6'b011110;
  localparam logic [5:0] OPC_J     = 6'b000010;
  localparam logic [5:0] OPC_JAL   = 6'b000011;
  localparam logic [5:0] OPC_LW    = 6'b100011;
  localparam logic [5:0] OPC_SW    = 6'b101011;

  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_JR   = 6'b001000;

  localparam int unsigned OPC_LSB = 26;
  localparam int unsigned RS_LSB  = 21;
  localparam int unsigned RT_LSB  = 16;
  localparam int unsigned RD_LSB  = 11;
  localparam int unsigned SH_LSB  = 6;
  localparam int unsigned FN_LSB  = 0;
  localparam int unsigned IMM_LSB = 0;
  localparam int unsigned TGT_LSB = 0;

endpackage

// File: rtl/instr_fifo.sv
// Word queue with wrapping pointers; read data is forced to zero while empty.
module instr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clr,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic                       ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;
  logic             do_push, do_pop;

  assign ready   = (count_q < FULL);
  assign valid   = (count_q != '0);
  assign count   = count_q;
  assign rdata   = valid ? mem_q[rd_ptr_q] : '0;
  // Push is gated on the pre-pop occupancy so a full queue never pushes through.
  assign do_push = push && ready;
  assign do_pop  = pop && valid;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = wdata;
        wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_q    <= '{default: '0};
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/instr_encoder.sv
// Encodes mnemonic requests into 32-bit instruction words, queues them and
// tags each emitted word with its instruction-memory byte address.
module instr_encoder
  import instr_pkg::*;
#(
  parameter int unsigned DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [4:0]             in_op,
  input  logic [4:0]             in_rs,
  input  logic [4:0]             in_rt,
  input  logic [4:0]             in_rd,
  input  logic [4:0]             in_shamt,
  input  logic [15:0]            in_imm,
  input  logic [25:0]            in_target,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_ir,
  output logic [31:0]            out_addr,
  output logic [$clog2(DEPTH):0] count,
  output logic                   err
);

  fmt_e        fmt;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic        legal;
  logic        use_rs, use_rt, use_rd, use_sh;
  logic [31:0] enc_ir;
  logic        accept, push, pop;
  logic [31:0] addr_q, addr_d;
  logic        err_q, err_d;

  always_comb begin
    fmt    = FMT_R;
    opcode = OPC_RTYPE;
    funct  = '0;
    legal  = 1'b1;
    use_rs = 1'b1;
    use_rt = 1'b1;
    use_rd = 1'b1;
    use_sh = 1'b0;
    case (in_op)
      OP_ADD:   funct = FN_ADD;
      OP_ADDU:  funct = FN_ADDU;
      OP_SUB:   funct = FN_SUB;
      OP_SUBU:  funct = FN_SUBU;
      OP_AND:   funct = FN_AND;
      OP_OR:    funct = FN_OR;
      OP_SLL:   begin funct = FN_SLL; use_rs = 1'b0; use_sh = 1'b1; end
      OP_SRL:   begin funct = FN_SRL; use_rs = 1'b0; use_sh = 1'b1; end
      OP_SLT:   funct = FN_SLT;
      OP_JR:    begin funct = FN_JR; use_rt = 1'b0; use_rd = 1'b0; end
      OP_ADDI:  begin fmt = FMT_I; opcode = OPC_ADDI;  end
      OP_ADDIU: begin fmt = FMT_I; opcode = OPC_ADDIU; end
      OP_SLTI:  begin fmt = FMT_I; opcode = OPC_SLTI;  end
      OP_SLTIU: begin fmt = FMT_I; opcode = OPC_SLTIU; end
      OP_ANDI:  begin fmt = FMT_I; opcode = OPC_ANDI;  end
      OP_ORI:   begin fmt = FMT_I; opcode = OPC_ORI;   end
      OP_BEQ:   begin fmt = FMT_I; opcode = OPC_BEQ;   end
      OP_BNE:   begin fmt = FMT_I; opcode = OPC_BNE;   end
      OP_BGT:   begin fmt = FMT_I; opcode = OPC_BGT;   end
      OP_BGTE:  begin fmt = FMT_I; opcode = OPC_BGTE;  end
      OP_BLE:   begin fmt = FMT_I; opcode = OPC_BLE;   end
      OP_BLEQ:  begin fmt = FMT_I; opcode = OPC_BLEQ;  end
      OP_LW:    begin fmt = FMT_I; opcode = OPC_LW;    end
      OP_SW:    begin fmt = FMT_I; opcode = OPC_SW;    end
      OP_J:     begin fmt = FMT_J; opcode = OPC_J;     end
      OP_JAL:   begin fmt = FMT_J; opcode = OPC_JAL;   end
      default:  legal = 1'b0;
    endcase
  end

  always_comb begin
    enc_ir = '0;
    enc_ir[OPC_LSB +: 6] = opcode;
    case (fmt)
      FMT_R: begin
        enc_ir[RS_LSB +: 5] = use_rs ? in_rs    : '0;
        enc_ir[RT_LSB +: 5] = use_rt ? in_rt    : '0;
        enc_ir[RD_LSB +: 5] = use_rd ? in_rd    : '0;
        enc_ir[SH_LSB +: 5] = use_sh ? in_shamt : '0;
        enc_ir[FN_LSB +: 6] = funct;
      end
      FMT_I: begin
        enc_ir[RS_LSB  +: 5]  = in_rs;
        enc_ir[RT_LSB  +: 5]  = in_rt;
        enc_ir[IMM_LSB +: 16] = in_imm;
      end
      default: enc_ir[TGT_LSB +: 26] = in_target;
    endcase
  end

  // Illegal requests still complete the handshake; they only raise err.
  assign accept = in_valid && in_ready && !flush;
  assign push   = accept && legal;
  assign pop    = out_valid && out_ready && !flush;

  instr_fifo #(
    .DEPTH(DEPTH),
    .WIDTH(32)
  ) u_fifo (
    .clk  (clk),
    .rst  (rst),
    .clr  (flush),
    .push (push),
    .wdata(enc_ir),
    .pop  (pop),
    .rdata(out_ir),
    .valid(out_valid),
    .ready(in_ready),
    .count(count)
  );

  always_comb begin
    addr_d = addr_q;
    err_d  = err_q;
    if (flush) begin
      addr_d = BASE_ADDR;
      err_d  = 1'b0;
    end else begin
      if (pop)              addr_d = addr_q + 32'd4;
      if (accept && !legal) err_d  = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= BASE_ADDR;
      err_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      err_q  <= err_d;
    end
  end

  assign out_addr = addr_q;
  assign err      = err_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Bench for instr_encoder: directed vector table, corner-case sequences and a
// randomized run against a queue-based reference model.
module tb_instr_encoder;

  localparam int unsigned DEPTH = 4;
  localparam logic [31:0] BASE  = 32'h0;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = '0, in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
  logic [15:0] in_imm = '0;
  logic [25:0] in_target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_ir, out_addr;
  logic [2:0]  count;
  logic        err;

  int checks = 0;
  int errors = 0;

  instr_encoder #(.DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd),
    .in_shamt(in_shamt), .in_imm(in_imm), .in_target(in_target),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_ir(out_ir), .out_addr(out_addr), .count(count), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic [4:0] op, input logic [4:0] rs, input logic [4:0] rt,
                       input logic [4:0] rd, input logic [4:0] sh, input logic [15:0] imm,
                       input logic [25:0] tgt);
    in_valid = 1'b1; in_op = op; in_rs = rs; in_rt = rt; in_rd = rd;
    in_shamt = sh; in_imm = imm; in_target = tgt;
  endtask

  // Reference encoder built from the mnemonic tables.
  localparam int FN_TAB [10]  = '{32, 33, 34, 35, 36, 37, 0, 2, 42, 8};
  localparam int OPC_TAB [16] = '{8, 9, 10, 11, 12, 13, 24, 25, 26, 27, 28, 30, 2, 3, 35, 43};

  function automatic logic [32:0] ref_encode(input int op, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
    int w;
    if (op <= 9) begin
      if (op == 6 || op == 7) rs = 0; else sh = 0;
      if (op == 9) begin rt = 0; rd = 0; end
      w = rs * (1 << 21) + rt * (1 << 16) + rd * (1 << 11) + sh * 64 + FN_TAB[op];
    end else if (op == 22 || op == 23) begin
      w = OPC_TAB[op - 10] * (1 << 26) + tgt;
    end else if (op <= 25) begin
      w = OPC_TAB[op - 10] * (1 << 26) + rs * (1 << 21) + rt * (1 << 16) + imm;
    end else begin
      return {1'b0, 32'h0};
    end
    return {1'b1, 32'(w)};
  endfunction

  typedef struct {
    string       name;
    logic [4:0]  op, rs, rt, rd, sh;
    logic [15:0] imm;
    logic [25:0] tgt;
    logic [31:0] exp_ir;
  } vec_t;

  vec_t vecs [10];
  logic [31:0] exp_words [5];
  logic [31:0] mq [$];
  logic [31:0] maddr;
  logic        merr;
  int          k;
  logic        pend;
  logic [32:0] e;

  initial begin
    vecs[0] = '{"add",  5'd0,  5'd1,  5'd2, 5'd3, 5'd5, 16'h0,    26'h0,   32'h00221820};
    vecs[1] = '{"addi", 5'd10, 5'd4,  5'd5, 5'd0, 5'd0, 16'hFFFF, 26'h0,   32'h2085FFFF};
    vecs[2] = '{"lw",   5'd24, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,   32'h8FA80004};
    vecs[3] = '{"j",    5'd22, 5'd3,  5'd3, 5'd3, 5'd3, 16'h1111, 26'h100, 32'h08000100};
    vecs[4] = '{"jal",  5'd23, 5'd0,  5'd0, 5'd0, 5'd0, 16'h0,    26'h100, 32'h0C000100};
    vecs[5] = '{"slt",  5'd8,  5'd1,  5'd2, 5'd3, 5'd9, 16'h0,    26'h0,   32'h0022182A};
    vecs[6] = '{"sll",  5'd6,  5'd7,  5'd2, 5'd3, 5'd4, 16'h0,    26'h0,   32'h00021900};
    vecs[7] = '{"jr",   5'd9,  5'd31, 5'd2, 5'd3, 5'd4, 16'h0,    26'h0,   32'h03E00008};
    vecs[8] = '{"bleq", 5'd21, 5'd1,  5'd2, 5'd0, 5'd0, 16'h1234, 26'h0,   32'h78221234};
    vecs[9] = '{"sw",   5'd25, 5'd29, 5'd8, 5'd0, 5'd0, 16'h0004, 26'h0,   32'hAFA80004};

    // Reset values
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_addr", out_addr, BASE);
    chk("rst_err", 32'(err), 0);
    chk("rst_ir", out_ir, 0);
    @(negedge clk); rst = 1'b0;

    // Vector table: one word at a time, consumer always ready
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      drive(vecs[i].op, vecs[i].rs, vecs[i].rt, vecs[i].rd, vecs[i].sh, vecs[i].imm, vecs[i].tgt);
      @(negedge clk);
      in_valid = 1'b0;
      chk({vecs[i].name, "_valid"}, 32'(out_valid), 1);
      chk({vecs[i].name, "_ir"}, out_ir, vecs[i].exp_ir);
      chk({vecs[i].name, "_addr"}, out_addr, BASE + 32'(4 * i));
    end

    // Backpressure: fill the queue, then drain in order
    @(negedge clk); flush = 1'b1; out_ready = 1'b0;
    @(negedge clk); flush = 1'b0;
    chk("flush_addr", out_addr, BASE);
    for (int i = 0; i < 5; i++) exp_words[i] = 32'h20000000 + 32'(i);
    for (int i = 0; i < 4; i++) begin
      chk("fill_ready", 32'(in_ready), 1);
      drive(5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 16'(i), 26'h0);
      @(negedge clk);
    end
    chk("full_count", 32'(count), 4);
    chk("full_ready", 32'(in_ready), 0);
    drive(5'd10, 5'd0, 5'd0, 5'd0, 5'd0, 16'd4, 26'h0);
    @(negedge clk);
    chk("full_hold_count", 32'(count), 4);
    chk("full_hold_ir", out_ir, exp_words[0]);
    chk("full_hold_addr", out_addr, BASE);
    out_ready = 1'b1;
    k = 0; pend = 1'b0;
    for (int c = 0; c < 30 && k < 5; c++) begin
      if (pend) in_valid = 1'b0;
      if (out_valid) begin
        chk("drain_ir", out_ir, exp_words[k]);
        chk("drain_addr", out_addr, BASE + 32'(4 * k));
        k++;
      end
      pend = in_valid && in_ready;
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("drain_words", 32'(k), 5);

    // Illegal op, then a legal one, then flush with a same-cycle request
    @(negedge clk);
    drive(5'd27, 5'd1, 5'd2, 5'd3, 5'd4, 16'h5, 26'h6);
    @(negedge clk);
    in_valid = 1'b0;
    chk("illegal_valid", 32'(out_valid), 0);
    chk("illegal_err", 32'(err), 1);
    drive(5'd8, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    chk("slt_after_ir", out_ir, 32'h0022182A);
    chk("err_sticky", 32'(err), 1);
    out_ready = 1'b1;
    flush = 1'b1;
    drive(5'd0, 5'd1, 5'd1, 5'd1, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_err", 32'(err), 0);
    chk("flush_count", 32'(count), 0);
    chk("flush_addr2", out_addr, BASE);
    chk("flush_valid", 32'(out_valid), 0);

    // Asynchronous reset with words queued
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(5'd5, 5'(i), 5'd1, 5'd2, 5'd0, 16'h0, 26'h0);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("q3_count", 32'(count), 3);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_count", 32'(count), 0);
    chk("arst_ir", out_ir, 0);
    @(negedge clk); rst = 1'b0;
    out_ready = 1'b1;
    drive(5'd1, 5'd1, 5'd2, 5'd3, 5'd0, 16'h0, 26'h0);
    @(negedge clk);
    in_valid = 1'b0;
    chk("post_rst_ir", out_ir, 32'h00221821);
    chk("post_rst_addr", out_addr, BASE);

    // Randomized run against the reference model
    @(negedge clk); flush = 1'b1; out_ready = 1'b0;
    @(negedge clk); flush = 1'b0;
    mq.delete(); maddr = BASE; merr = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      chk("rnd_valid", 32'(out_valid), 32'(mq.size() != 0));
      chk("rnd_ir", out_ir, (mq.size() != 0) ? mq[0] : 32'h0);
      chk("rnd_addr", out_addr, maddr);
      chk("rnd_count", 32'(count), 32'(mq.size()));
      chk("rnd_ready", 32'(in_ready), 32'(mq.size() < DEPTH));
      chk("rnd_err", 32'(err), 32'(merr));
      in_valid  = ($urandom_range(0, 3) != 0);
      in_op     = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(26, 31)) : 5'($urandom_range(0, 25));
      in_rs     = 5'($urandom); in_rt = 5'($urandom); in_rd = 5'($urandom);
      in_shamt  = 5'($urandom); in_imm = 16'($urandom); in_target = 26'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 63) == 0);
      if (flush) begin
        mq.delete(); maddr = BASE; merr = 1'b0;
      end else begin
        logic acc;
        acc = in_valid && (mq.size() < DEPTH);
        e = ref_encode(int'(in_op), int'(in_rs), int'(in_rt), int'(in_rd), int'(in_shamt),
                       int'(in_imm), int'(in_target));
        if (out_ready && mq.size() != 0) begin
          void'(mq.pop_front());
          maddr = maddr + 32'd4;
        end
        if (acc) begin
          if (e[32]) mq.push_back(e[31:0]);
          else       merr = 1'b1;
        end
      end
      @(negedge clk);
    end
    flush = 1'b0; in_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
